// File: rtl/led_display_row_scheduler.sv
// BCM row-pair sequencer: fetches each (row, plane) word from frame RAM, hands it to the PHY, then holds the dwell window.
// Optional feature macro LED_DISPLAY_DOUBLE_BUFFER_EN adds a swap-at-frame-boundary buffer select bit.
`timescale 1ns/1ps
module led_display_row_scheduler #(
  parameter int NUM_ROW_ADDR = 16,
  parameter int NUM_PLANES   = 4,
  parameter int ROW_W        = 384,
  parameter int BASE_TICKS   = 64,
  parameter int RAM_LATENCY  = 2
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             enable_in,
  output logic             ram_en_out,
  output logic [12:0]      ram_addr_out,
  input  logic [ROW_W-1:0] ram_rdata_in,
  output logic [ROW_W-1:0] row_out,
  output logic             row_valid_out,
  input  logic             row_ready_in,
  output logic [3:0]       row_address_out,
  output logic             display_en_out,
  output logic             frame_done_out,
  input  logic             swap_req_in,
  output logic             swap_ack_out
);
  localparam int RA_W = $clog2(NUM_ROW_ADDR);
  localparam int PL_W = $clog2(NUM_PLANES);
  localparam int RC_W = (RA_W < 1) ? 1 : RA_W;
  localparam int PC_W = (PL_W < 1) ? 1 : PL_W;
  localparam int DW_W = $clog2(BASE_TICKS << (NUM_PLANES-1)) + 1;
  localparam int LT_W = 3;

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, PRESENT, DWELL, ADVANCE} state_t;

  state_t            state_q, state_d;
  logic [RC_W-1:0]   row_q, row_d;
  logic [PC_W-1:0]   plane_q, plane_d;
  logic [LT_W-1:0]   wait_q, wait_d;
  logic [DW_W-1:0]   dwell_q, dwell_d;
  logic [ROW_W-1:0]  data_q, data_d;
  logic [3:0]        raddr_q, raddr_d;
  logic              buf_sel;
  logic              plane_last, row_last;

`ifdef LED_DISPLAY_DOUBLE_BUFFER_EN
  logic buf_q, buf_d, pend_q, pend_d;
  assign buf_sel = buf_q;
`else
  logic unused_swap_req;
  assign unused_swap_req = swap_req_in;
  assign buf_sel = 1'b0;
`endif

  assign plane_last      = (plane_q == PC_W'(NUM_PLANES-1));
  assign row_last        = (row_q == RC_W'(NUM_ROW_ADDR-1));
  assign ram_addr_out    = 13'(row_q) | (13'(plane_q) << RA_W) | (13'(buf_sel) << (RA_W+PL_W));
  assign row_out         = data_q;
  assign row_address_out = raddr_q;

  always_comb begin
    state_d        = state_q;
    row_d          = row_q;
    plane_d        = plane_q;
    wait_d         = wait_q;
    dwell_d        = dwell_q;
    data_d         = data_q;
    raddr_d        = raddr_q;
    ram_en_out     = 1'b0;
    row_valid_out  = 1'b0;
    display_en_out = 1'b0;
    frame_done_out = 1'b0;
    swap_ack_out   = 1'b0;
`ifdef LED_DISPLAY_DOUBLE_BUFFER_EN
    buf_d  = buf_q;
    pend_d = pend_q | swap_req_in;
`endif
    case (state_q)
      IDLE: begin
        row_d   = '0;
        plane_d = '0;
        if (enable_in) state_d = FETCH;
      end
      FETCH: begin
        ram_en_out = 1'b1;
        wait_d     = LT_W'(RAM_LATENCY-1);
        state_d    = WAIT;
      end
      WAIT: begin
        if (wait_q == '0) begin
          data_d  = ram_rdata_in;
          raddr_d = 4'(row_q);
          state_d = PRESENT;
        end else begin
          wait_d = wait_q - LT_W'(1);
        end
      end
      PRESENT: begin
        row_valid_out = 1'b1;
        if (row_ready_in) begin
          dwell_d = DW_W'(BASE_TICKS) << plane_q;
          state_d = DWELL;
        end
      end
      DWELL: begin
        // Exits after the cycle the count hits 1, so the window is exactly the loaded length.
        display_en_out = 1'b1;
        dwell_d        = dwell_q - DW_W'(1);
        if (dwell_q == DW_W'(1)) state_d = ADVANCE;
      end
      ADVANCE: begin
        if (plane_last) begin
          plane_d = '0;
          if (row_last) begin
            row_d          = '0;
            frame_done_out = 1'b1;
`ifdef LED_DISPLAY_DOUBLE_BUFFER_EN
            // A request arriving in this very cycle still counts for this boundary.
            if (pend_q | swap_req_in) begin
              buf_d        = ~buf_q;
              swap_ack_out = 1'b1;
              pend_d       = 1'b0;
            end
`endif
          end else begin
            row_d = row_q + RC_W'(1);
          end
        end else begin
          plane_d = plane_q + PC_W'(1);
        end
        if (enable_in) begin
          state_d = FETCH;
        end else begin
          state_d = IDLE;
          row_d   = '0;
          plane_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= IDLE;
      row_q   <= '0;
      plane_q <= '0;
      wait_q  <= '0;
      dwell_q <= '0;
      data_q  <= '0;
      raddr_q <= '0;
`ifdef LED_DISPLAY_DOUBLE_BUFFER_EN
      buf_q   <= 1'b0;
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      plane_q <= plane_d;
      wait_q  <= wait_d;
      dwell_q <= dwell_d;
      data_q  <= data_d;
      raddr_q <= raddr_d;
`ifdef LED_DISPLAY_DOUBLE_BUFFER_EN
      buf_q   <= buf_d;
      pend_q  <= pend_d;
`endif
    end
  end
endmodule

// File: tb/tb_led_display_row_scheduler.sv
// Self-checking bench for led_display_row_scheduler: random frame RAM contents against a scan-order reference model.
`timescale 1ns/1ps
module tb_led_display_row_scheduler;
  localparam int NRA = 2, NPL = 2, RW = 384, BT = 4, LAT = 2;
`ifdef LED_DISPLAY_DOUBLE_BUFFER_EN
  localparam int DB = 1;
`else
  localparam int DB = 0;
`endif

  logic clk_in = 1'b0, reset_in = 1'b1, enable_in = 1'b0, row_ready_in = 1'b1, swap_req_in = 1'b0;
  logic ram_en_out, row_valid_out, display_en_out, frame_done_out, swap_ack_out;
  logic [12:0] ram_addr_out;
  logic [RW-1:0] ram_rdata_in, row_out;
  logic [3:0] row_address_out;

  logic en4 = 1'b0, ram_en4, valid4, de4, fd4, ack4;
  logic [12:0] addr4;
  logic [RW-1:0] rdata4 = '0, row4;
  logic [3:0] ra4;

  int checks = 0, errors = 0;
  logic [RW-1:0] mem [0:7];
  logic [LAT-1:0] pv = '0;
  logic [2:0] pa [0:LAT-1];
  logic [RW-1:0] junk = '0;

  led_display_row_scheduler #(.NUM_ROW_ADDR(NRA), .NUM_PLANES(NPL), .ROW_W(RW), .BASE_TICKS(BT), .RAM_LATENCY(LAT)) dut (
    .clk_in(clk_in), .reset_in(reset_in), .enable_in(enable_in), .ram_en_out(ram_en_out),
    .ram_addr_out(ram_addr_out), .ram_rdata_in(ram_rdata_in), .row_out(row_out),
    .row_valid_out(row_valid_out), .row_ready_in(row_ready_in), .row_address_out(row_address_out),
    .display_en_out(display_en_out), .frame_done_out(frame_done_out), .swap_req_in(swap_req_in),
    .swap_ack_out(swap_ack_out));

  led_display_row_scheduler #(.NUM_ROW_ADDR(NRA), .NUM_PLANES(NPL), .ROW_W(RW), .BASE_TICKS(BT), .RAM_LATENCY(4)) dut4 (
    .clk_in(clk_in), .reset_in(reset_in), .enable_in(en4), .ram_en_out(ram_en4),
    .ram_addr_out(addr4), .ram_rdata_in(rdata4), .row_out(row4),
    .row_valid_out(valid4), .row_ready_in(1'b1), .row_address_out(ra4),
    .display_en_out(de4), .frame_done_out(fd4), .swap_req_in(1'b0), .swap_ack_out(ack4));

  always #25 clk_in = ~clk_in;

  function automatic logic [RW-1:0] rand_row();
    logic [RW-1:0] v;
    for (int w = 0; w < RW/32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  // Frame RAM model: data for a strobed address appears LAT cycles later, junk otherwise.
  always @(posedge clk_in) begin
    pv    <= {pv[LAT-2:0], ram_en_out};
    pa[0] <= ram_addr_out[2:0];
    for (int i = 1; i < LAT; i++) pa[i] <= pa[i-1];
    junk  <= rand_row();
  end
  assign ram_rdata_in = pv[LAT-1] ? mem[pa[LAT-1]] : junk;

  // Reference scan order: row outer, plane inner, buffer select on top.
  function automatic logic [12:0] exp_addr(input int b, input int k);
    return 13'(b*NRA*NPL + (k % NPL)*NRA + k / NPL);
  endfunction

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset;
    reset_in = 1'b1; enable_in = 1'b0; swap_req_in = 1'b0; row_ready_in = 1'b1; en4 = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = rand_row();
    tick; tick;
    reset_in = 1'b0;
  endtask

  // Walks one item with ready high and reports what was observed; no judgement here.
  task automatic run_item(input int req_cyc, input int drop_cyc,
                          output logic [12:0] addr, output int lat, output logic [RW-1:0] rdat,
                          output logic [3:0] ra, output int width, output logic fd,
                          output logic ack, output bit to);
    to = 1'b0; addr = '0; lat = 0; rdat = '0; ra = '0; width = 0; fd = 1'b0; ack = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick; swap_req_in = 1'b0;
      if (ram_en_out) break;
    end
    if (!ram_en_out) begin to = 1'b1; return; end
    addr = ram_addr_out;
    for (int i = 0; i < 20; i++) begin
      tick; lat++;
      if (row_valid_out) break;
    end
    if (!row_valid_out) begin to = 1'b1; return; end
    rdat = row_out; ra = row_address_out;
    for (int i = 0; i < 2000; i++) begin
      tick; swap_req_in = 1'b0;
      if (!display_en_out) break;
      if (width == req_cyc) swap_req_in = 1'b1;
      if (width == drop_cyc) enable_in = 1'b0;
      width++;
    end
    if (display_en_out) begin to = 1'b1; return; end
    if (req_cyc == -2) begin swap_req_in = 1'b1; #1; end
    fd = frame_done_out; ack = swap_ack_out;
  endtask

  task automatic test_reset;
    reset_in = 1'b1; enable_in = 1'b1; en4 = 1'b1; row_ready_in = 1'b1;
    tick; tick;
    checks++;
    if ({ram_en_out, ram_addr_out, row_valid_out, row_address_out, display_en_out, frame_done_out, swap_ack_out} !== 22'd0) begin
      errors++;
      $display("FAIL reset_ctrl got %h want 0", {ram_en_out, ram_addr_out, row_valid_out, row_address_out, display_en_out, frame_done_out, swap_ack_out});
    end
    checks++;
    if (row_out !== '0) begin errors++; $display("FAIL reset_row got %h want 0", row_out); end
    checks++;
    if ({ram_en4, addr4, valid4, ra4, de4, fd4, ack4, row4} !== '0) begin
      errors++; $display("FAIL reset_lat4 outputs not all zero");
    end
    enable_in = 1'b0; en4 = 1'b0;
  endtask

  task automatic test_full_frame;
    logic [12:0] a; int lat, w; logic [RW-1:0] d; logic [3:0] ra; logic fd, ack; bit to;
    do_reset;
    enable_in = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < NRA*NPL; k++) begin
        run_item(-1, -1, a, lat, d, ra, w, fd, ack, to);
        checks++;
        if (to) begin errors++; $display("FAIL frame_timeout f%0d k%0d", f, k); return; end
        checks++;
        if (a !== exp_addr(0, k)) begin errors++; $display("FAIL frame_addr f%0d k%0d got %h want %h", f, k, a, exp_addr(0, k)); end
        checks++;
        if (lat != LAT+1) begin errors++; $display("FAIL frame_latency f%0d k%0d got %0d want %0d", f, k, lat, LAT+1); end
        checks++;
        if (d !== mem[exp_addr(0, k)]) begin errors++; $display("FAIL frame_row_data f%0d k%0d got %h want %h", f, k, d, mem[exp_addr(0, k)]); end
        checks++;
        if (ra !== 4'(k / NPL)) begin errors++; $display("FAIL frame_row_addr f%0d k%0d got %0d want %0d", f, k, ra, k / NPL); end
        checks++;
        if (w != (BT << (k % NPL))) begin errors++; $display("FAIL frame_dwell f%0d k%0d got %0d want %0d", f, k, w, BT << (k % NPL)); end
        checks++;
        if (fd !== (k == NRA*NPL-1)) begin errors++; $display("FAIL frame_done f%0d k%0d got %b want %b", f, k, fd, k == NRA*NPL-1); end
        checks++;
        if (ack !== 1'b0) begin errors++; $display("FAIL frame_swap_ack f%0d k%0d got %b want 0", f, k, ack); end
      end
    end
    enable_in = 1'b0;
  endtask

  task automatic test_backpressure;
    logic [RW-1:0] r; logic [3:0] ra; int bad, w;
    do_reset;
    row_ready_in = 1'b0; enable_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (row_valid_out) break;
    end
    checks++;
    if (!row_valid_out) begin errors++; $display("FAIL bp_valid_timeout got 0 want 1"); return; end
    r = row_out; ra = row_address_out;
    checks++;
    if (r !== mem[0]) begin errors++; $display("FAIL bp_row_data got %h want %h", r, mem[0]); end
    bad = 0;
    for (int i = 1; i < 10; i++) begin
      tick;
      if (row_valid_out !== 1'b1 || row_out !== r || row_address_out !== ra || display_en_out !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_hold_stable got %0d unstable cycles want 0", bad); end
    tick;
    row_ready_in = 1'b1;
    checks++;
    if (row_valid_out !== 1'b1 || display_en_out !== 1'b0) begin
      errors++; $display("FAIL bp_last_hold got valid=%b en=%b want valid=1 en=0", row_valid_out, display_en_out);
    end
    tick;
    checks++;
    if (display_en_out !== 1'b1 || row_valid_out !== 1'b0) begin
      errors++; $display("FAIL bp_dwell_start got en=%b valid=%b want en=1 valid=0", display_en_out, row_valid_out);
    end
    w = 0;
    for (int i = 0; i < 100 && display_en_out; i++) begin w++; tick; end
    checks++;
    if (w != BT) begin errors++; $display("FAIL bp_dwell_width got %0d want %0d", w, BT); end
    enable_in = 1'b0;
  endtask

  task automatic test_enable_drop;
    logic [12:0] a; int lat, w, bad, drop; logic [RW-1:0] d; logic [3:0] ra; logic fd, ack; bit to;
    do_reset;
    enable_in = 1'b1;
    run_item(-1, -1, a, lat, d, ra, w, fd, ack, to);
    drop = $urandom_range(0, 6);
    run_item(-1, drop, a, lat, d, ra, w, fd, ack, to);
    checks++;
    if (to) begin errors++; $display("FAIL drop_timeout"); return; end
    checks++;
    if (a !== exp_addr(0, 1)) begin errors++; $display("FAIL drop_addr got %h want %h", a, exp_addr(0, 1)); end
    checks++;
    if (w != 2*BT) begin errors++; $display("FAIL drop_dwell got %0d want %0d (drop at %0d)", w, 2*BT, drop); end
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (ram_en_out || row_valid_out || display_en_out) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL drop_idle got %0d active cycles want 0", bad); end
    enable_in = 1'b1;
    tick;
    checks++;
    if (ram_en_out !== 1'b1 || ram_addr_out !== 13'h000) begin
      errors++; $display("FAIL drop_restart got en=%b addr=%h want en=1 addr=000", ram_en_out, ram_addr_out);
    end
    enable_in = 1'b0;
  endtask

  task automatic test_async_reset;
    do_reset;
    enable_in = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick;
      if (display_en_out) break;
    end
    checks++;
    if (!display_en_out) begin errors++; $display("FAIL areset_no_dwell got 0 want 1"); return; end
    repeat ($urandom_range(0, 2)) tick;
    #10 reset_in = 1'b1;
    #1;
    checks++;
    if (display_en_out !== 1'b0 || row_valid_out !== 1'b0 || ram_en_out !== 1'b0 || ram_addr_out !== 13'h000) begin
      errors++; $display("FAIL areset_immediate got en=%b valid=%b ram_en=%b addr=%h want all 0",
                         display_en_out, row_valid_out, ram_en_out, ram_addr_out);
    end
    tick; tick;
    reset_in = 1'b0;
    tick;
    checks++;
    if (ram_en_out !== 1'b1 || ram_addr_out !== 13'h000) begin
      errors++; $display("FAIL areset_restart got en=%b addr=%h want en=1 addr=000", ram_en_out, ram_addr_out);
    end
    enable_in = 1'b0;
  endtask

  task automatic test_double_buffer;
    logic [12:0] a; int lat, w, req, b; logic [RW-1:0] d; logic [3:0] ra; logic fd, ack; bit to;
    int exp_ack;
    do_reset;
    enable_in = 1'b1;
    b = 0;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < NRA*NPL; k++) begin
        req = -1;
        if (f == 0 && k == 0) req = 1;
        if (f == 0 && k == 2) req = 0;
        if (f == 1 && k == NRA*NPL-1) req = -2;
        run_item(req, -1, a, lat, d, ra, w, fd, ack, to);
        checks++;
        if (to) begin errors++; $display("FAIL dbuf_timeout f%0d k%0d", f, k); swap_req_in = 1'b0; return; end
        checks++;
        if (a !== exp_addr(b, k)) begin errors++; $display("FAIL dbuf_addr f%0d k%0d got %h want %h", f, k, a, exp_addr(b, k)); end
        checks++;
        if (d !== mem[exp_addr(b, k)]) begin errors++; $display("FAIL dbuf_data f%0d k%0d got %h want %h", f, k, d, mem[exp_addr(b, k)]); end
        exp_ack = (k == NRA*NPL-1 && f < 2) ? DB : 0;
        checks++;
        if (ack !== 1'(exp_ack)) begin errors++; $display("FAIL dbuf_ack f%0d k%0d got %b want %0d", f, k, ack, exp_ack); end
        if (k == NRA*NPL-1) begin
          checks++;
          if (fd !== 1'b1) begin errors++; $display("FAIL dbuf_frame_done f%0d got %b want 1", f, fd); end
        end
      end
      if (f < 2 && DB == 1) b = 1 - b;
    end
    swap_req_in = 1'b0; enable_in = 1'b0;
  endtask

  task automatic test_latency4;
    int cnt; logic [RW-1:0] exp_row; bit seen;
    do_reset;
    en4 = 1'b1;
    for (int item = 0; item < 2; item++) begin
      seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
        tick; rdata4 = rand_row();
        if (ram_en4) begin seen = 1'b1; break; end
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL lat4_strobe_timeout item%0d", item); return; end
      cnt = 0; exp_row = '0;
      for (int i = 0; i < 20; i++) begin
        tick; rdata4 = rand_row(); cnt++;
        if (cnt == 4) exp_row = rdata4;
        if (valid4) break;
      end
      checks++;
      if (cnt != 5) begin errors++; $display("FAIL lat4_valid_delay item%0d got %0d want 5", item, cnt); end
      checks++;
      if (row4 !== exp_row) begin errors++; $display("FAIL lat4_row_data item%0d got %h want %h", item, row4, exp_row); end
    end
    en4 = 1'b0;
  endtask

  initial begin
    test_reset;
    test_full_frame;
    test_backpressure;
    test_enable_drop;
    test_async_reset;
    test_double_buffer;
    test_latency4;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/led_display_row_scheduler.md
# led_display_row_scheduler

Sequences row delivery for the 64x32 RGB LED panel. It fetches each row-pair bit plane from frame RAM, presents it to the display driver PHY over a valid/ready handshake, then holds the output-enable window for a binary-weighted dwell time. This implements binary code modulation (BCM) brightness. It sits between frame RAM and the driver PHY in the 20 MHz display clock domain, replacing the pattern generator as the row source.

## Interface
- NUM_ROW_ADDR, 16: row-pair addresses scanned per frame (A..D lines).
- NUM_PLANES, 4: BCM bit planes per colour.
- ROW_W, 384: width of one row-pair word (64 cols x 6 bits).
- BASE_TICKS, 64: dwell cycles for plane 0; plane p dwells BASE_TICKS<<p cycles.
- RAM_LATENCY, 2: cycles from ram_en_out to valid ram_rdata_in (1..4).

Ports:
- clk_in  in  1  display clock (20 MHz).
- reset_in  in  1  asynchronous, active-high reset.
- enable_in  in  1  scanning permitted.
- ram_en_out  in/out: out  1  RAM read strobe, one cycle per fetch.
- ram_addr_out  out  13  {buf, plane, row} zero-extended: row in [RA_W-1:0], plane in [RA_W+PL_W-1:RA_W], buf at bit RA_W+PL_W (RA_W=clog2(NUM_ROW_ADDR), PL_W=clog2(NUM_PLANES)).
- ram_rdata_in  in  ROW_W  RAM read data.
- row_out  out  ROW_W  registered row-pair data.
- row_valid_out  out  1  row_out/row_address_out valid.
- row_ready_in  in  1  PHY accepts row.
- row_address_out  out  4  row address travelling with row_out.
- display_en_out  out  1  high during dwell window (top level derives OE).
- frame_done_out  out  1  one-cycle pulse after last item of a frame.
- swap_req_in  in  1  request buffer swap (see Configuration).
- swap_ack_out  out  1  one-cycle pulse when swap applied.

## Operation
- Scan order: row outer, plane inner: (r0,p0),(r0,p1)..(r0,pN-1),(r1,p0)... Each frame contains NUM_ROW_ADDR*NUM_PLANES items.
- FSM states: IDLE, FETCH, WAIT, PRESENT, DWELL, ADVANCE.
- IDLE: row and plane counters at 0. Goes to FETCH when enable_in=1.
- FETCH: one cycle. ram_en_out=1 and ram_addr_out driven from counters. Goes to WAIT.
- WAIT: counts RAM_LATENCY cycles. On the last cycle, ram_rdata_in is captured into row_out and the current row goes to row_address_out. Goes to PRESENT.
- PRESENT: row_valid_out=1. row_out and row_address_out are held stable until row_valid_out & row_ready_in. On transfer: goes to DWELL and loads the dwell counter with BASE_TICKS<<plane.
- DWELL: display_en_out=1. The counter decrements and the state exits when the count reaches 0, giving exactly BASE_TICKS<<plane high cycles.
- ADVANCE: one cycle. Plane increments; on wrap to 0, row increments. On row wrap, frame_done_out is pulsed and any pending swap is applied.
  - Then if enable_in=1, go to FETCH.
  - Otherwise, reset counters to 0 and go to IDLE.
- enable_in is sampled only in IDLE and ADVANCE. Deasserting it never truncates a dwell or a pending handshake.
- Dwell counter width: clog2(BASE_TICKS<<(NUM_PLANES-1))+1 bits. No overflow at max plane.

## Timing
- Reset value of every output is 0: ram_en_out, ram_addr_out, row_out, row_valid_out, row_address_out, display_en_out, frame_done_out, swap_ack_out. The FSM resets to IDLE and counters to 0.
- Reset mid-operation forces all outputs to 0 immediately (asynchronous). Scanning restarts from (r0,p0).
- Latency:
  - enable_in high in IDLE at cycle 0 -> ram_en_out at cycle 1.
  - row_valid_out rises RAM_LATENCY+1 cycles after ram_en_out.
- Handshake: valid never drops without a transfer. Ready may be held high permanently, giving a 1-cycle PRESENT.
- display_en_out rises in the cycle after the transfer and falls before the next ram_en_out.
- Per-item cycles with ready held high: 1 + RAM_LATENCY + 1 + BASE_TICKS<<p + 1.

## Configuration
- LED_DISPLAY_DOUBLE_BUFFER_EN defined:
  - An internal buffer-select bit drives the buf field of ram_addr_out.
  - swap_req_in is latched sticky, and repeated requests before the boundary collapse to one.
  - At the frame-boundary ADVANCE, the select bit toggles, swap_ack_out pulses, and the sticky latch clears.
  - If swap_req_in and the boundary occur in the same cycle, the swap applies at that boundary.
- Undefined:
  - The buf bit is always 0.
  - swap_req_in is ignored and swap_ack_out is held 0.

## Test plan
Bench parameters: NUM_ROW_ADDR=2, NUM_PLANES=2, BASE_TICKS=4, RAM_LATENCY=2, row_ready_in=1.
- Full frame: enable_in=1 -> addresses 0x000, 0x002, 0x001, 0x003 in that order. display_en_out high widths 4, 8, 4, 8. One frame_done_out pulse after the fourth dwell.
- Backpressure: hold row_ready_in=0 for 10 cycles in PRESENT -> row_valid_out, row_out and row_address_out stable for all 10 cycles. Dwell starts the cycle after ready rises.
- Enable drop: clear enable_in during the (r0,p1) dwell -> dwell completes all 8 cycles, FSM returns to IDLE, next enable restarts at address 0x000.
- Async reset: assert reset_in mid-DWELL -> display_en_out and row_valid_out go to 0 in the same cycle. After release and enable, first ram_addr_out=0x000.
- Double buffer (macro on): pulse swap_req_in in the first item -> swap_ack_out pulses with frame_done_out, and the next frame addresses are 0x004..0x007. Without the macro, addresses stay 0x000..0x003 and swap_ack_out stays 0.
- Latency check: RAM_LATENCY=4 -> row_valid_out rises exactly 5 cycles after ram_en_out, and row_out equals ram_rdata_in sampled 4 cycles after the strobe.
